// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: execute-stage consumer of comparator flags.
// Resolves bne/blt, computes the branch target, drives a registered redirect
// to fetch, holds squash for FLUSH_CYCLES cycles after a taken branch, and
// raises add/addi/sub overflow exceptions with their rstatus code.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accepting instructions; branches and exceptions act
// SQUASH | wrong-path window; valid_in ignored, counter runs down to 0
module branch_resolve_unit #(
    parameter int PC_WIDTH     = 32,
    parameter int IMM_WIDTH    = 17,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic                 op_bne,
    input  logic                 op_blt,
    input  logic                 op_add,
    input  logic                 op_addi,
    input  logic                 op_sub,
    input  logic                 is_not_equal,
    input  logic                 is_less_than,
    input  logic                 overflow,
    input  logic [PC_WIDTH-1:0]  pc_plus1,
    input  logic [IMM_WIDTH-1:0] imm,
    output logic                 redirect,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 squash,
    output logic                 exc_valid,
    output logic [31:0]          exc_code
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SQUASH = 1'b1
    } state_t;

    // Counter loads FLUSH_CYCLES-1: the redirect cycle itself is the first squash cycle.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);
    // A single-cycle flush is fully covered by the redirect cycle, so no SQUASH visit.
    localparam state_t TAKEN_NEXT = (FLUSH_CYCLES > 1) ? S_SQUASH : S_IDLE;

    state_t               r_state;
    logic [3:0]           r_count;
    logic                 r_redirect;
    logic [PC_WIDTH-1:0]  r_redirect_pc;
    logic                 r_squash;
    logic                 r_exc_valid;
    logic [31:0]          r_exc_code;

    state_t               w_state_nxt;
    logic [3:0]           w_count_nxt;
    logic                 w_redirect_nxt;
    logic [PC_WIDTH-1:0]  w_redirect_pc_nxt;
    logic                 w_squash_nxt;
    logic                 w_exc_valid_nxt;
    logic [31:0]          w_exc_code_nxt;

    logic                 w_is_branch;
    logic                 w_taken;
    logic [1:0]           w_arith_code;
    logic                 w_exc;
    logic [PC_WIDTH-1:0]  w_target;

    // Opcode decode with fixed priority bne > blt > add > addi > sub.
    always_comb begin
        w_is_branch  = op_bne | op_blt;
        w_taken      = valid_in & (op_bne ? is_not_equal : (op_blt & is_less_than));
        w_arith_code = 2'd0;
        if (op_add) begin
            w_arith_code = 2'd1;
        end else if (op_addi) begin
            w_arith_code = 2'd2;
        end else if (op_sub) begin
            w_arith_code = 2'd3;
        end
        w_exc    = valid_in & ~w_is_branch & overflow & (w_arith_code != 2'd0);
        w_target = pc_plus1 + {{(PC_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    end

    // State register plus registered outputs; reset aborts any squash at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_count       <= 4'd0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_squash      <= 1'b0;
            r_exc_valid   <= 1'b0;
            r_exc_code    <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_squash      <= w_squash_nxt;
            r_exc_valid   <= w_exc_valid_nxt;
            r_exc_code    <= w_exc_code_nxt;
        end
    end

    // Next-state and flush counter.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_taken) begin
                    w_state_nxt = TAKEN_NEXT;
                    w_count_nxt = CNT_LOAD;
                end
            end
            S_SQUASH: begin
                if (r_count == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt = r_count - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = 4'd0;
            end
        endcase
    end

    // Next output values; in SQUASH the instruction stream is wrong-path and ignored.
    always_comb begin
        w_redirect_nxt    = 1'b0;
        w_squash_nxt      = 1'b0;
        w_exc_valid_nxt   = 1'b0;
        if (r_state == S_IDLE) begin
            w_redirect_nxt  = w_taken;
            w_squash_nxt    = w_taken;
            w_exc_valid_nxt = w_exc;
        end else begin
            w_squash_nxt    = (r_count != 4'd0);
        end
        w_redirect_pc_nxt = w_redirect_nxt ? w_target : r_redirect_pc;
        w_exc_code_nxt    = w_exc_valid_nxt ? {30'd0, w_arith_code} : r_exc_code;
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign squash      = r_squash;
    assign exc_valid   = r_exc_valid;
    assign exc_code    = r_exc_code;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: two instances (flush 2 and flush 4) share stimulus.
module tb_branch_resolve_unit;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b10000;
    localparam logic [4:0] OP_BLT  = 5'b01000;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00001;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [4:0]  ops;
    logic        is_not_equal, is_less_than, overflow;
    logic [31:0] pc_plus1;
    logic [16:0] imm;

    logic        redirect_o [2];
    logic [31:0] pc_o       [2];
    logic        squash_o   [2];
    logic        exc_valid_o[2];
    logic [31:0] exc_code_o [2];

    // behavioural reference: per instance, outputs plus number of upcoming ignored edges
    int          flush_of [2] = '{2, 4};
    logic        m_red [2];
    logic [31:0] m_pc  [2];
    logic        m_sq  [2];
    logic        m_exv [2];
    logic [31:0] m_code[2];
    int          m_ign [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    branch_resolve_unit #(.PC_WIDTH(32), .IMM_WIDTH(17), .FLUSH_CYCLES(2)) u_f2 (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .op_bne(ops[4]), .op_blt(ops[3]), .op_add(ops[2]), .op_addi(ops[1]), .op_sub(ops[0]),
        .is_not_equal(is_not_equal), .is_less_than(is_less_than), .overflow(overflow),
        .pc_plus1(pc_plus1), .imm(imm),
        .redirect(redirect_o[0]), .redirect_pc(pc_o[0]), .squash(squash_o[0]),
        .exc_valid(exc_valid_o[0]), .exc_code(exc_code_o[0]));

    branch_resolve_unit #(.PC_WIDTH(32), .IMM_WIDTH(17), .FLUSH_CYCLES(4)) u_f4 (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .op_bne(ops[4]), .op_blt(ops[3]), .op_add(ops[2]), .op_addi(ops[1]), .op_sub(ops[0]),
        .is_not_equal(is_not_equal), .is_less_than(is_less_than), .overflow(overflow),
        .pc_plus1(pc_plus1), .imm(imm),
        .redirect(redirect_o[1]), .redirect_pc(pc_o[1]), .squash(squash_o[1]),
        .exc_valid(exc_valid_o[1]), .exc_code(exc_code_o[1]));

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_red[k] = 1'b0; m_pc[k] = 32'd0; m_sq[k] = 1'b0;
            m_exv[k] = 1'b0; m_code[k] = 32'd0; m_ign[k] = 0;
        end
    endtask

    task automatic model_edge();
        int  off;
        logic taken;
        off = int'($signed(imm));
        for (int k = 0; k < 2; k++) begin
            m_red[k] = 1'b0;
            m_exv[k] = 1'b0;
            if (m_ign[k] > 0) begin
                m_ign[k] = m_ign[k] - 1;
                m_sq[k]  = (m_ign[k] > 0);
            end else begin
                m_sq[k] = 1'b0;
                if (valid_in) begin
                    if (ops[4] || ops[3]) begin
                        taken = ops[4] ? is_not_equal : is_less_than;
                        if (taken) begin
                            m_red[k] = 1'b1;
                            m_sq[k]  = 1'b1;
                            m_pc[k]  = pc_plus1 + 32'(off);
                            m_ign[k] = (flush_of[k] == 1) ? 0 : flush_of[k];
                        end
                    end else if (overflow && ops[2:0] != 3'b000) begin
                        m_exv[k]  = 1'b1;
                        m_code[k] = ops[2] ? 32'd1 : (ops[1] ? 32'd2 : 32'd3);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] o, input logic ne, input logic lt,
                         input logic ov, input logic [31:0] pc, input logic [16:0] im);
        valid_in = v; ops = o; is_not_equal = ne; is_less_than = lt;
        overflow = ov; pc_plus1 = pc; imm = im;
    endtask

    task automatic idle(input int n);
        drive(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 17'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        idle(2);
        reset = 1'b0;
        drive(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'h100, 17'h1FFFC);
        tick();
        n_vec++;
        if (redirect_o[0] !== 1'b1 || squash_o[0] !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_nonzero got red=%0b sq=%0b want 1 1", redirect_o[0], squash_o[0]);
        end
        #2 reset = 1'b1;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (redirect_o[k] !== 1'b0 || pc_o[k] !== 32'd0 || squash_o[k] !== 1'b0 ||
                exc_valid_o[k] !== 1'b0 || exc_code_o[k] !== 32'd0) begin
                n_err++;
                $display("FAIL async_reset[%0d] got red=%0b pc=%h sq=%0b exv=%0b code=%0d want all 0",
                         k, redirect_o[k], pc_o[k], squash_o[k], exc_valid_o[k], exc_code_o[k]);
            end
        end
        idle(1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (redirect_o[0] !== 1'b0 || pc_o[0] !== 32'd0 || squash_o[0] !== 1'b0 ||
                exc_valid_o[0] !== 1'b0 || exc_code_o[0] !== 32'd0) begin
                n_err++;
                $display("FAIL post_reset_idle got red=%0b pc=%h sq=%0b exv=%0b want all 0",
                         redirect_o[0], pc_o[0], squash_o[0], exc_valid_o[0]);
            end
        end
    endtask

    task automatic test_taken_bne();
        logic exp_sq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        drive(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'h100, 17'h1FFFC);
        tick();
        n_vec++;
        if (redirect_o[0] !== 1'b1 || pc_o[0] !== 32'h000000FC) begin
            n_err++; $display("FAIL bne_target got red=%0b pc=%h want 1 000000fc", redirect_o[0], pc_o[0]);
        end
        drive(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 17'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (squash_o[0] !== exp_sq[i] || (i > 0 && redirect_o[0] !== 1'b0) || pc_o[0] !== 32'h000000FC) begin
                n_err++;
                $display("FAIL bne_squash_len cyc%0d got sq=%0b red=%0b pc=%h want sq=%0b",
                         i, squash_o[0], redirect_o[0], pc_o[0], exp_sq[i]);
            end
        end
        idle(4);
    endtask

    task automatic test_untaken_wrap();
        drive(1'b1, OP_BLT, 1'b1, 1'b0, 1'b0, 32'h500, 17'd5);
        tick();
        n_vec++;
        if (redirect_o[0] !== 1'b0 || squash_o[0] !== 1'b0 || pc_o[0] !== 32'h000000FC) begin
            n_err++; $display("FAIL blt_untaken got red=%0b sq=%0b pc=%h want 0 0 000000fc",
                              redirect_o[0], squash_o[0], pc_o[0]);
        end
        drive(1'b1, OP_BLT, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 17'd1);
        tick();
        n_vec++;
        if (redirect_o[0] !== 1'b1 || pc_o[0] !== 32'h00000000) begin
            n_err++; $display("FAIL blt_wrap got red=%0b pc=%h want 1 00000000", redirect_o[0], pc_o[0]);
        end
        idle(5);
    endtask

    task automatic test_overflow_codes();
        logic [4:0]  op_tab  [3] = '{OP_ADD, OP_ADDI, OP_SUB};
        logic [31:0] code_tab[3] = '{32'd1, 32'd2, 32'd3};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, op_tab[i], 1'b0, 1'b0, 1'b1, 32'h40, 17'd0);
            tick();
            n_vec++;
            if (exc_valid_o[0] !== 1'b1 || exc_code_o[0] !== code_tab[i] || redirect_o[0] !== 1'b0) begin
                n_err++; $display("FAIL ovf_code%0d got exv=%0b code=%0d red=%0b want 1 %0d 0",
                                  i, exc_valid_o[0], exc_code_o[0], redirect_o[0], code_tab[i]);
            end
            idle(1);
            n_vec++;
            if (exc_valid_o[0] !== 1'b0 || exc_code_o[0] !== code_tab[i]) begin
                n_err++; $display("FAIL ovf_pulse_hold%0d got exv=%0b code=%0d want 0 %0d",
                                  i, exc_valid_o[0], exc_code_o[0], code_tab[i]);
            end
        end
        drive(1'b1, OP_BNE, 1'b0, 1'b0, 1'b1, 32'h40, 17'd8);
        tick();
        n_vec++;
        if (exc_valid_o[0] !== 1'b0 || redirect_o[0] !== 1'b0 || exc_code_o[0] !== 32'd3) begin
            n_err++; $display("FAIL bne_ovf_ignored got exv=%0b red=%0b code=%0d want 0 0 3",
                              exc_valid_o[0], redirect_o[0], exc_code_o[0]);
        end
        drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1, 32'h40, 17'd0);
        tick();
        n_vec++;
        if (exc_valid_o[0] !== 1'b0 || exc_code_o[0] !== 32'd3) begin
            n_err++; $display("FAIL invalid_ovf_ignored got exv=%0b code=%0d want 0 3",
                              exc_valid_o[0], exc_code_o[0]);
        end
        idle(1);
    endtask

    task automatic test_squash_mask();
        drive(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'h200, 17'h10);
        tick();
        n_vec++;
        if (redirect_o[0] !== 1'b1 || pc_o[0] !== 32'h210) begin
            n_err++; $display("FAIL mask_first got red=%0b pc=%h want 1 00000210", redirect_o[0], pc_o[0]);
        end
        drive(1'b1, OP_SUB, 1'b0, 1'b0, 1'b1, 32'h280, 17'd0);
        tick();
        n_vec++;
        if (exc_valid_o[0] !== 1'b0 || redirect_o[0] !== 1'b0 || squash_o[0] !== 1'b1) begin
            n_err++; $display("FAIL mask_sub got exv=%0b red=%0b sq=%0b want 0 0 1",
                              exc_valid_o[0], redirect_o[0], squash_o[0]);
        end
        drive(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'h300, 17'd0);
        tick();
        n_vec++;
        if (exc_valid_o[0] !== 1'b0 || redirect_o[0] !== 1'b0 || pc_o[0] !== 32'h210) begin
            n_err++; $display("FAIL mask_bne got exv=%0b red=%0b pc=%h want 0 0 00000210",
                              exc_valid_o[0], redirect_o[0], pc_o[0]);
        end
        drive(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'h400, 17'd4);
        tick();
        n_vec++;
        if (redirect_o[0] !== 1'b1 || pc_o[0] !== 32'h404 || squash_o[0] !== 1'b1) begin
            n_err++; $display("FAIL mask_third got red=%0b pc=%h sq=%0b want 1 00000404 1",
                              redirect_o[0], pc_o[0], squash_o[0]);
        end
        idle(6);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, OP_BNE, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i), 17'd0);
            tick();
            n_vec++;
            if (redirect_o[0] !== (i % 3 == 0) || squash_o[0] !== (i % 3 != 2)) begin
                n_err++; $display("FAIL back_to_back cyc%0d got red=%0b sq=%0b want %0b %0b",
                                  i, redirect_o[0], squash_o[0], (i % 3 == 0), (i % 3 != 2));
            end
        end
        idle(6);
    endtask

    task automatic test_reset_mid_squash();
        int sq_cnt;
        drive(1'b1, OP_BLT, 1'b0, 1'b1, 1'b0, 32'h1000, 17'h1FFFF);
        tick();
        idle(1);
        n_vec++;
        if (squash_o[1] !== 1'b1 || pc_o[1] !== 32'hFFF) begin
            n_err++; $display("FAIL f4_second_cycle got sq=%0b pc=%h want 1 00000fff", squash_o[1], pc_o[1]);
        end
        #2 reset = 1'b1;
        model_clear();
        #1;
        n_vec++;
        if (squash_o[1] !== 1'b0 || redirect_o[1] !== 1'b0 || pc_o[1] !== 32'd0) begin
            n_err++; $display("FAIL f4_reset_abort got sq=%0b red=%0b pc=%h want 0 0 0",
                              squash_o[1], redirect_o[1], pc_o[1]);
        end
        idle(1);
        reset = 1'b0;
        drive(1'b1, OP_BLT, 1'b0, 1'b1, 1'b0, 32'h20, 17'd2);
        tick();
        n_vec++;
        if (redirect_o[1] !== 1'b1 || pc_o[1] !== 32'h22) begin
            n_err++; $display("FAIL f4_restart got red=%0b pc=%h want 1 00000022", redirect_o[1], pc_o[1]);
        end
        sq_cnt = squash_o[1] ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, OP_BLT, 1'b0, 1'b1, 1'b0, 32'h900, 17'd0);
            if (i >= 3) drive(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 17'd0);
            tick();
            if (squash_o[1]) sq_cnt++;
        end
        n_vec++;
        if (sq_cnt !== 4) begin
            n_err++; $display("FAIL f4_squash_len got %0d want 4", sq_cnt);
        end
        idle(6);
    endtask

    task automatic test_random();
        logic [4:0] o;
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 6))
                0: o = OP_BNE; 1: o = OP_BLT; 2: o = OP_ADD; 3: o = OP_ADDI; 4: o = OP_SUB;
                5: o = 5'($urandom_range(0, 31));
                default: o = OP_NONE;
            endcase
            drive(($urandom_range(0, 9) < 8), o, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, 17'($urandom));
            tick();
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (redirect_o[k] !== m_red[k] || pc_o[k] !== m_pc[k] || squash_o[k] !== m_sq[k] ||
                    exc_valid_o[k] !== m_exv[k] || exc_code_o[k] !== m_code[k]) begin
                    n_err++;
                    $display("FAIL random[%0d] inst%0d got red=%0b pc=%h sq=%0b exv=%0b code=%0d want red=%0b pc=%h sq=%0b exv=%0b code=%0d",
                             i, k, redirect_o[k], pc_o[k], squash_o[k], exc_valid_o[k], exc_code_o[k],
                             m_red[k], m_pc[k], m_sq[k], m_exv[k], m_code[k]);
                end
                n_vec++;
                if (redirect_o[k] && exc_valid_o[k]) begin
                    n_err++; $display("FAIL random_exclusive[%0d] inst%0d got red=1 exv=1 want not both", i, k);
                end
            end
        end
        idle(6);
    endtask

    initial begin
        drive(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0, 32'd0, 17'd0);
        test_reset();
        test_taken_bne();
        test_untaken_wrap();
        test_overflow_codes();
        test_squash_mask();
        test_back_to_back();
        test_reset_mid_squash();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
